// File: rtl/adbg_apb4_biu.sv
// -----------------------------------------------------------------------------
// adbg_apb4_biu
//
// Purpose:
//   Bridges the debug bus core's BIU request interface onto an APB4 master port.
//   Every accepted request produces exactly one APB4 transfer (SETUP + ACCESS).
//   Requests with an illegal size or alignment complete at once with an error
//   and issue no APB cycle. Write data is replicated across byte lanes. Read
//   data is shifted down and masked so that the core always sees it
//   right-justified.
//
// Handshake (biu side):
//   The core raises biu_strb and holds it until it sees biu_rdy. biu_rdy is a
//   single-cycle pulse, and biu_err is meaningful only while biu_rdy is high.
//   After the pulse the block waits for biu_strb to fall before it accepts
//   another request, so a level that stays high never starts a second transfer.
//
// Optional feature (macro ADBG_APB4_BIU_TIMEOUT_EN):
//   When the macro is defined, an 8-bit watchdog aborts an ACCESS phase that
//   has not seen PREADY within TIMEOUT_CYCLES cycles, and reports biu_err.
//   When it is undefined, ACCESS waits for PREADY indefinitely.
//
// Ports:
//   biu_clk, biu_rst        clock (also PCLK), synchronous active-high reset
//   biu_strb, biu_rw        request level, 1 = write
//   biu_addr, biu_di        byte address, right-justified write data
//   biu_word_size           access size in bytes (1, 2 or 4 are legal)
//   biu_do, biu_rdy, biu_err  read data, completion pulse, error flag
//   PSEL..PPROT             APB4 master outputs
//   PRDATA, PREADY, PSLVERR APB4 slave responses
//   dbg_state               current FSM state (IDLE=0, SETUP=1, ACCESS=2, DONE=3)
// -----------------------------------------------------------------------------
module adbg_apb4_biu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst,
  input  logic                  biu_strb,
  input  logic                  biu_rw,
  input  logic [ADDR_WIDTH-1:0] biu_addr,
  input  logic [DATA_WIDTH-1:0] biu_di,
  input  logic [3:0]            biu_word_size,
  output logic [DATA_WIDTH-1:0] biu_do,
  output logic                  biu_rdy,
  output logic                  biu_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  // Only 32-bit data is supported, and the watchdog limit must fit the 8-bit
  // counter.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_param_check
    $error("adbg_apb4_biu: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  // Captured request attributes that the read-return alignment needs later.
  logic [1:0] addr_lo_q;
  logic [3:0] size_q;

  // Request decode, evaluated against the live biu_* inputs while in IDLE.
  logic                  req_legal;
  logic [3:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_wdata;

  always_comb begin
    req_legal  = 1'b0;
    lane_strb  = 4'b0000;
    lane_wdata = '0;
    case (biu_word_size)
      4'd1: begin
        req_legal  = 1'b1;
        lane_strb  = 4'b0001 << biu_addr[1:0];
        lane_wdata = {4{biu_di[7:0]}};
      end
      4'd2: begin
        req_legal  = ~biu_addr[0];
        lane_strb  = 4'b0011 << biu_addr[1:0];
        lane_wdata = {2{biu_di[15:0]}};
      end
      4'd4: begin
        req_legal  = (biu_addr[1:0] == 2'b00);
        lane_strb  = 4'b1111;
        lane_wdata = biu_di;
      end
      default: begin
        req_legal  = 1'b0;
      end
    endcase
  end

  // Read-return path: move the addressed lane down to bit 0, then clear the
  // bytes that lie outside the access size.
  logic [DATA_WIDTH-1:0] rdata_shift;
  logic [DATA_WIDTH-1:0] rdata_aligned;

  assign rdata_shift = PRDATA >> {addr_lo_q, 3'b000};

  always_comb begin
    rdata_aligned = rdata_shift;
    case (size_q)
      4'd1:    rdata_aligned = {{(DATA_WIDTH-8){1'b0}}, rdata_shift[7:0]};
      4'd2:    rdata_aligned = {{(DATA_WIDTH-16){1'b0}}, rdata_shift[15:0]};
      default: rdata_aligned = rdata_shift;
    endcase
  end

  // Watchdog: timeout_hit flags the last ACCESS cycle before an abort. A
  // PREADY in that same cycle takes priority, because both the FSM and the
  // output register test PREADY first.
  logic timeout_hit;

`ifdef ADBG_APB4_BIU_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge biu_clk) begin
    if (biu_rst) begin
      to_cnt <= 8'd0;
    end else if (state == SETUP) begin
      to_cnt <= 8'd0;
    end else if (state == ACCESS && !PREADY) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (biu_strb) state_next = req_legal ? SETUP : DONE;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) state_next = DONE;
      end
      DONE: begin
        if (!biu_strb) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs. biu_rdy and biu_err default low every
  // cycle, so each of them is a one-cycle pulse.
  always_ff @(posedge biu_clk) begin
    if (biu_rst) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= 4'b0000;
      biu_do    <= '0;
      biu_rdy   <= 1'b0;
      biu_err   <= 1'b0;
      addr_lo_q <= 2'b00;
      size_q    <= 4'd0;
    end else begin
      state   <= state_next;
      biu_rdy <= 1'b0;
      biu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (biu_strb) begin
            if (req_legal) begin
              PSEL      <= 1'b1;
              PENABLE   <= 1'b0;
              PADDR     <= {biu_addr[ADDR_WIDTH-1:2], 2'b00};
              PWRITE    <= biu_rw;
              PSTRB     <= biu_rw ? lane_strb : 4'b0000;
              PWDATA    <= lane_wdata;
              addr_lo_q <= biu_addr[1:0];
              size_q    <= biu_word_size;
            end else begin
              biu_rdy <= 1'b1;
              biu_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            biu_rdy <= 1'b1;
            biu_err <= PSLVERR;
            // biu_do changes only when a read completes without an error.
            if (!PWRITE && !PSLVERR) biu_do <= rdata_aligned;
          end else if (timeout_hit) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            biu_rdy <= 1'b1;
            biu_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign PPROT     = 3'b001;
  assign dbg_state = state;

endmodule

// File: tb/tb_adbg_apb4_biu.sv
// -----------------------------------------------------------------------------
// tb_adbg_apb4_biu
//
// Directed bench for adbg_apb4_biu. The driver issues requests with
// hand-computed expectations. Each request pushes one expected completion into
// resp_q, and each legal request also pushes the expected APB SETUP phase into
// apb_q. Two monitors pop from these queues whenever the DUT presents biu_rdy
// or an APB SETUP phase. The APB slave model answers with a programmable
// number of wait states.
// -----------------------------------------------------------------------------
module tb_adbg_apb4_biu;

  localparam int TB_TIMEOUT = 16;

  logic        clk;
  logic        biu_rst;
  logic        biu_strb;
  logic        biu_rw;
  logic [31:0] biu_addr;
  logic [31:0] biu_di;
  logic [3:0]  biu_word_size;
  logic [31:0] biu_do;
  logic        biu_rdy;
  logic        biu_err;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [1:0]  dbg_state;

  adbg_apb4_biu #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .biu_clk       (clk),
    .biu_rst       (biu_rst),
    .biu_strb      (biu_strb),
    .biu_rw        (biu_rw),
    .biu_addr      (biu_addr),
    .biu_di        (biu_di),
    .biu_word_size (biu_word_size),
    .biu_do        (biu_do),
    .biu_rdy       (biu_rdy),
    .biu_err       (biu_err),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PADDR         (PADDR),
    .PWRITE        (PWRITE),
    .PWDATA        (PWDATA),
    .PSTRB         (PSTRB),
    .PPROT         (PPROT),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- scoreboard
  int tests_run    = 0;
  int tests_failed = 0;

  // resp entry: {lat[7:0], err, do[31:0]}
  logic [40:0] resp_q[$];
  // apb entry: {paddr[31:0], pwrite, pstrb[3:0], pwdata[31:0], check_wdata}
  logic [69:0] apb_q[$];
  logic [69:0] cur_apb;
  int          issue_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // Completion monitor.
  initial begin
    logic [40:0] e;
    forever begin
      @(negedge clk);
      if (!biu_rst && biu_rdy) begin
        if (resp_q.size() == 0) begin
          fail_now("unexpected_rdy");
        end else begin
          e = resp_q.pop_front();
          check("rdy_err", 64'(biu_err), 64'(e[32]));
          check("rdy_do", 64'(biu_do), 64'(e[31:0]));
          check("rdy_latency", 64'(cyc - issue_cyc + 1), 64'(e[40:33]));
        end
      end
    end
  end

  // APB monitor: checks the SETUP phase against the expected item, then
  // checks that ACCESS holds the same values.
  initial begin
    cur_apb = '0;
    forever begin
      @(negedge clk);
      if (PSEL && !PENABLE) begin
        if (apb_q.size() == 0) begin
          fail_now("unexpected_psel");
        end else begin
          cur_apb = apb_q.pop_front();
          check("setup_paddr", 64'(PADDR), 64'(cur_apb[69:38]));
          check("setup_pwrite", 64'(PWRITE), 64'(cur_apb[37]));
          check("setup_pstrb", 64'(PSTRB), 64'(cur_apb[36:33]));
          if (cur_apb[0]) check("setup_pwdata", 64'(PWDATA), 64'(cur_apb[32:1]));
          check("pprot", 64'(PPROT), 64'h1);
        end
      end else if (PSEL && PENABLE) begin
        check("access_paddr", 64'(PADDR), 64'(cur_apb[69:38]));
        check("access_pstrb", 64'(PSTRB), 64'(cur_apb[36:33]));
        if (cur_apb[0]) check("access_pwdata", 64'(PWDATA), 64'(cur_apb[32:1]));
      end
    end
  end

  // ---------------------------------------------------------------- APB slave
  int          sl_waits = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err   = 1'b0;

  initial begin
    int wcnt;
    wcnt    = 0;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (PSEL && PENABLE) begin
        if (wcnt >= sl_waits) begin
          PREADY  = 1'b1;
          PRDATA  = sl_rdata;
          PSLVERR = sl_err;
        end else begin
          PREADY  = 1'b0;
          PRDATA  = $urandom;
          PSLVERR = 1'b0;
          wcnt++;
        end
      end else begin
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic req(input logic rw, input logic [31:0] addr, input logic [31:0] di,
                     input logic [3:0] size, input int waits, input logic [31:0] rdata,
                     input logic slverr, input int hold, input bit legal,
                     input logic [31:0] e_paddr, input logic [3:0] e_pstrb,
                     input logic [31:0] e_pwdata, input logic e_err,
                     input logic [31:0] e_do, input int e_lat);
    int guard;
    sl_waits = waits;
    sl_rdata = rdata;
    sl_err   = slverr;
    if (legal) apb_q.push_back({e_paddr, rw, e_pstrb, e_pwdata, rw});
    resp_q.push_back({8'(e_lat), e_err, e_do});
    biu_rw        = rw;
    biu_addr      = addr;
    biu_di        = di;
    biu_word_size = size;
    biu_strb      = 1'b1;
    issue_cyc     = cyc + 1;
    @(negedge clk);
    // Changing the request inputs after capture must not affect the transfer.
    biu_rw        = 1'($urandom_range(0, 1));
    biu_addr      = $urandom;
    biu_di        = $urandom;
    biu_word_size = 4'($urandom_range(0, 15));
    guard = 0;
    while (!biu_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("rdy_timeout");
    repeat (hold) @(negedge clk);
    biu_strb = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_in_access();
    int guard;
    sl_waits = 10;
    sl_rdata = 32'hFFFF_FFFF;
    sl_err   = 1'b0;
    apb_q.push_back({32'h0000_0080, 1'b0, 4'h0, 32'h0, 1'b0});
    biu_rw        = 1'b0;
    biu_addr      = 32'h0000_0080;
    biu_di        = '0;
    biu_word_size = 4'd4;
    biu_strb      = 1'b1;
    guard = 0;
    while (!(PSEL && PENABLE) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) fail_now("reach_access");
    @(negedge clk);
    biu_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_psel", 64'(PSEL), 64'h0);
    check("rst_mid_penable", 64'(PENABLE), 64'h0);
    check("rst_mid_rdy", 64'(biu_rdy), 64'h0);
    check("rst_mid_state", 64'(dbg_state), 64'h0);
    check("rst_mid_do", 64'(biu_do), 64'h0);
    biu_strb = 1'b0;
    biu_rst  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    biu_rst       = 1'b1;
    biu_strb      = 1'b0;
    biu_rw        = 1'b0;
    biu_addr      = '0;
    biu_di        = '0;
    biu_word_size = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_psel", 64'(PSEL), 64'h0);
    check("reset_penable", 64'(PENABLE), 64'h0);
    check("reset_pwrite", 64'(PWRITE), 64'h0);
    check("reset_rdy", 64'(biu_rdy), 64'h0);
    check("reset_err", 64'(biu_err), 64'h0);
    check("reset_paddr", 64'(PADDR), 64'h0);
    check("reset_pwdata", 64'(PWDATA), 64'h0);
    check("reset_pstrb", 64'(PSTRB), 64'h0);
    check("reset_do", 64'(biu_do), 64'h0);
    check("reset_state", 64'(dbg_state), 64'h0);
    biu_rst = 1'b0;
    @(negedge clk);

    // Arguments: rw addr di size waits rdata slverr hold legal | paddr pstrb pwdata err do lat
    // Word write, zero wait states.
    req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'd4, 0, 32'h0, 1'b0, 0, 1'b1,
        32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 3);
    // Byte read at lane 3, three wait states.
    req(1'b0, 32'h0000_2003, 32'h0, 4'd1, 3, 32'hA500_0000, 1'b0, 0, 1'b1,
        32'h0000_2000, 4'h0, 32'h0, 1'b0, 32'h0000_00A5, 6);
    // Halfword write to the upper half; upper bits of di must be ignored.
    req(1'b1, 32'h0000_0002, 32'hABCD_1234, 4'd2, 0, 32'h0, 1'b0, 0, 1'b1,
        32'h0000_0000, 4'hC, 32'h1234_1234, 1'b0, 32'h0000_00A5, 3);
    // Misaligned halfword: immediate error, no APB cycle.
    req(1'b0, 32'h0000_0001, 32'h0, 4'd2, 0, 32'h0, 1'b0, 0, 1'b0,
        32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_00A5, 1);
    // Size 8 with strb held five cycles: one pulse only.
    req(1'b1, 32'h0000_0000, 32'h0, 4'd8, 0, 32'h0, 1'b0, 4, 1'b0,
        32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_00A5, 1);
    // Size 3 is not a legal size.
    req(1'b0, 32'h0000_0000, 32'h0, 4'd3, 0, 32'h0, 1'b0, 0, 1'b0,
        32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_00A5, 1);
    // Misaligned word.
    req(1'b1, 32'h0000_0102, 32'h0, 4'd4, 0, 32'h0, 1'b0, 0, 1'b0,
        32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_00A5, 1);
    // Byte write at lane 3, strb held after completion.
    req(1'b1, 32'h0000_3003, 32'h0000_775A, 4'd1, 0, 32'h0, 1'b0, 2, 1'b1,
        32'h0000_3000, 4'h8, 32'h5A5A_5A5A, 1'b0, 32'h0000_00A5, 3);
    // Halfword read from the upper half.
    req(1'b0, 32'h0000_4002, 32'h0, 4'd2, 0, 32'hBEEF_1234, 1'b0, 0, 1'b1,
        32'h0000_4000, 4'h0, 32'h0, 1'b0, 32'h0000_BEEF, 3);
    // Byte read from lane 1, one wait state.
    req(1'b0, 32'h0000_5001, 32'h0, 4'd1, 1, 32'h1100_C3FF, 1'b0, 0, 1'b1,
        32'h0000_5000, 4'h0, 32'h0, 1'b0, 32'h0000_00C3, 4);
    // Slave error on a read: err set, biu_do keeps its previous value.
    req(1'b0, 32'h0000_0010, 32'h0, 4'd4, 1, 32'h1111_1111, 1'b1, 0, 1'b1,
        32'h0000_0010, 4'h0, 32'h0, 1'b1, 32'h0000_00C3, 4);
    // Slave error on a write.
    req(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'd4, 0, 32'h0, 1'b1, 0, 1'b1,
        32'h0000_0020, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0000_00C3, 3);

    reset_in_access();

    // Recovery after the mid-transfer reset (biu_do was cleared by reset).
    req(1'b0, 32'h0000_0040, 32'h0, 4'd4, 2, 32'h0102_0304, 1'b0, 0, 1'b1,
        32'h0000_0040, 4'h0, 32'h0, 1'b0, 32'h0102_0304, 5);

`ifdef ADBG_APB4_BIU_TIMEOUT_EN
    // No PREADY: abort after TB_TIMEOUT ACCESS cycles (SETUP + 16 ACCESS + 1).
    req(1'b0, 32'h0000_0044, 32'h0, 4'd4, 100, 32'h0, 1'b0, 0, 1'b1,
        32'h0000_0044, 4'h0, 32'h0, 1'b1, 32'h0102_0304, TB_TIMEOUT + 2);
`endif

    repeat (5) @(negedge clk);
    check("resp_q_drained", 64'(resp_q.size()), 64'h0);
    check("apb_q_drained", 64'(apb_q.size()), 64'h0);
    check("final_psel", 64'(PSEL), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    fail_now("global_watchdog");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
